// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 key schedule: sizes, controller states
// and the 4-bit S-box / inverse S-box tables.
package present_pkg;

    localparam int KEY_W = 80;
    localparam int RK_W  = 64;
    localparam int NKEYS = 32;

    localparam logic [5:0] FIRST_IDX = 6'd1;
    localparam logic [5:0] LAST_IDX  = 6'(NKEYS);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_READY,
        ST_SEEK
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_key_schedule_key_update_step.sv
// One combinational PRESENT-80 key-register update, forward (K_i -> K_i+1)
// or inverse (K_i -> K_i-1); the inverse undoes the forward ops in reverse order.
module key_update_step
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] k_in,
    input  logic [4:0]       ctr,
    input  logic             inv,
    output logic [KEY_W-1:0] k_next
);

    logic [KEY_W-1:0] fwd_rot;
    logic [KEY_W-1:0] fwd_key;
    logic [KEY_W-1:0] inv_xor;
    logic [KEY_W-1:0] inv_sub;
    logic [KEY_W-1:0] inv_key;

    assign fwd_rot = {k_in[18:0], k_in[79:19]};
    assign fwd_key = {sbox(fwd_rot[79:76]), fwd_rot[75:20],
                      fwd_rot[19:15] ^ ctr, fwd_rot[14:0]};

    assign inv_xor = {k_in[79:20], k_in[19:15] ^ ctr, k_in[14:0]};
    assign inv_sub = {sbox_inv(inv_xor[79:76]), inv_xor[75:0]};
    assign inv_key = {inv_sub[60:0], inv_sub[79:61]};

    assign k_next = inv ? inv_key : fwd_key;

endmodule

// File: rtl/present_key_schedule.sv
// Sequential PRESENT-80 key schedule: holds the key register, steps it forward
// or backward on request, and can seek autonomously to the final key K32.
module present_key_schedule
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             seek,
    input  logic             step,
    input  logic             dir,
    output logic [KEY_W-1:0] k_out,
    output logic [RK_W-1:0]  rk,
    output logic [5:0]       key_idx,
    output logic             valid,
    output logic             busy,
    output logic             step_err
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [5:0]       idx_q, idx_d;
    logic             err_q, err_d;

    logic             upd_inv;
    logic [5:0]       idx_m1;
    logic [4:0]       upd_ctr;
    logic [KEY_W-1:0] key_step;

    // Only READY ever steps backward; SEEK always runs forward.
    assign upd_inv = (state_q == ST_READY) && dir;
    assign idx_m1  = idx_q - 6'd1;
    assign upd_ctr = upd_inv ? idx_m1[4:0] : idx_q[4:0];

    key_update_step u_step (
        .k_in   (key_q),
        .ctr    (upd_ctr),
        .inv    (upd_inv),
        .k_next (key_step)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        err_d   = 1'b0;

        if (load) begin
            key_d   = key_in;
            idx_d   = FIRST_IDX;
            state_d = ST_READY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    err_d = step;
                end
                ST_READY: begin
                    if (seek) begin
                        // seek wins over a simultaneous step, which is dropped.
                        err_d = step;
                        if (idx_q != LAST_IDX) state_d = ST_SEEK;
                    end else if (step) begin
                        if ((!dir && idx_q == LAST_IDX) || (dir && idx_q == FIRST_IDX)) begin
                            err_d = 1'b1;
                        end else begin
                            key_d = key_step;
                            idx_d = dir ? idx_m1 : idx_q + 6'd1;
                        end
                    end
                end
                ST_SEEK: begin
                    err_d = step;
                    key_d = key_step;
                    idx_d = idx_q + 6'd1;
                    if (idx_q == LAST_IDX - 6'd1) state_d = ST_READY;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments keep every register update order-independent.
    always_ff @(posedge clk) begin
        // NOTE: the key register is reset too, since k_out must read zero after reset.
        if (rst) begin
            state_q <= ST_EMPTY;
            key_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign k_out    = key_q;
    assign rk       = key_q[79:16];
    assign key_idx  = idx_q;
    assign valid    = (state_q == ST_READY);
    assign busy     = (state_q == ST_SEEK);
    assign step_err = err_q;

endmodule

// File: tb/tb_present_key_schedule.sv
// Self-checking bench for present_key_schedule against a table of round keys
// expanded by a plain PRESENT-80 key-schedule model.
module tb_present_key_schedule;

    logic        clk = 1'b0;
    logic        rst, load, seek, step, dir;
    logic [79:0] key_in;
    logic [79:0] k_out;
    logic [63:0] rk;
    logic [5:0]  key_idx;
    logic        valid, busy, step_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [79:0] golden [1:32];
    logic [3:0]  s_tab  [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .key_in   (key_in),
        .seek     (seek),
        .step     (step),
        .dir      (dir),
        .k_out    (k_out),
        .rk       (rk),
        .key_idx  (key_idx),
        .valid    (valid),
        .busy     (busy),
        .step_err (step_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Round keys K1..K32 from the textbook PRESENT-80 key schedule.
    task automatic expand(input logic [79:0] key);
        logic [79:0] k;
        k = key;
        golden[1] = k;
        for (int i = 1; i < 32; i++) begin
            k = (k << 61) | (k >> 19);
            k[79:76] = s_tab[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(i);
            golden[i+1] = k;
        end
    endtask

    function automatic logic [79:0] rand_key();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic do_load(input logic [79:0] key);
        load = 1'b1; key_in = key;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_seek_done(output int cycles);
        cycles = 0;
        while (busy && cycles < 64) begin
            cycles++;
            tick();
        end
        check("seek_terminates", 80'(busy), 80'(0));
    endtask

    initial begin
        logic [79:0] key_a, key_b;
        int          cyc, idx_m;
        logic        st, d, err_m;

        rst = 1'b1; load = 1'b0; seek = 1'b0; step = 1'b0; dir = 1'b0; key_in = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid",   80'(valid),    80'(0));
        check("rst_idx",     80'(key_idx),  80'(0));
        check("rst_kout",    k_out,         80'(0));
        check("rst_busy",    80'(busy),     80'(0));
        check("rst_steperr", 80'(step_err), 80'(0));

        // Step in EMPTY is rejected.
        step = 1'b1; tick(); step = 1'b0;
        check("empty_step_err", 80'(step_err), 80'(1));
        check("empty_idx",      80'(key_idx),  80'(0));

        // Zero key: known K2 value, then back to K1, then underflow rejection.
        do_load('0);
        check("k1_zero",  k_out,        80'(0));
        check("k1_idx",   80'(key_idx), 80'(1));
        check("k1_valid", 80'(valid),   80'(1));
        step = 1'b1; dir = 1'b0; tick(); step = 1'b0;
        check("k2_kout", k_out,        80'hC000_0000_0000_0000_8000);
        check("k2_rk",   80'(rk),      80'hC000_0000_0000_0000);
        check("k2_idx",  80'(key_idx), 80'(2));
        step = 1'b1; dir = 1'b1; tick();
        check("back_kout", k_out,         80'(0));
        check("back_idx",  80'(key_idx),  80'(1));
        check("back_err",  80'(step_err), 80'(0));
        tick(); step = 1'b0;
        check("under_err",  80'(step_err), 80'(1));
        check("under_kout", k_out,         80'(0));
        check("under_idx",  80'(key_idx),  80'(1));
        tick();
        check("err_one_cycle", 80'(step_err), 80'(0));

        // Seek to K32, walk back to K1, then overflow rejection at K32.
        key_a = rand_key();
        expand(key_a);
        do_load(key_a);
        seek = 1'b1; tick(); seek = 1'b0;
        wait_seek_done(cyc);
        check("seek_busy_cycles", 80'(cyc),     80'(31));
        check("seek_valid",       80'(valid),   80'(1));
        check("seek_idx",         80'(key_idx), 80'(32));
        check("seek_k32",         k_out,        golden[32]);
        step = 1'b1; dir = 1'b1;
        for (int i = 31; i >= 1; i--) begin
            tick();
            check($sformatf("inv_k%0d", i), k_out, golden[i]);
        end
        step = 1'b0;
        check("inv_back_to_key", k_out,        key_a);
        check("inv_idx1",        80'(key_idx), 80'(1));
        seek = 1'b1; tick(); seek = 1'b0;
        wait_seek_done(cyc);
        step = 1'b1; dir = 1'b0; tick(); step = 1'b0;
        check("over_err",  80'(step_err), 80'(1));
        check("over_idx",  80'(key_idx),  80'(32));
        check("over_kout", k_out,         golden[32]);

        // Seek at K32 does nothing.
        seek = 1'b1; tick(); seek = 1'b0;
        check("seek_at_end_busy", 80'(busy),    80'(0));
        check("seek_at_end_idx",  80'(key_idx), 80'(32));

        // Back-to-back forward steps against golden round keys, then seek agrees.
        key_b = rand_key();
        expand(key_b);
        do_load(key_b);
        step = 1'b1; dir = 1'b0;
        for (int i = 2; i <= 32; i++) begin
            tick();
            check($sformatf("fwd_rk%0d", i), 80'(rk), 80'(golden[i][79:16]));
        end
        step = 1'b0;
        check("fwd_k32", k_out, golden[32]);
        do_load(key_b);
        seek = 1'b1; tick(); seek = 1'b0;
        wait_seek_done(cyc);
        check("seek_eq_steps", k_out, golden[32]);

        // seek and step together: seek wins, step reported as rejected.
        do_load(key_b);
        seek = 1'b1; step = 1'b1; tick(); seek = 1'b0; step = 1'b0;
        check("seek_step_err",  80'(step_err), 80'(1));
        check("seek_step_busy", 80'(busy),     80'(1));
        check("seek_step_idx",  80'(key_idx),  80'(1));
        wait_seek_done(cyc);

        // Random walk with boundary tracking.
        expand(key_a);
        do_load(key_a);
        idx_m = 1;
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(0, 1));
            d  = (n < 20) ? 1'b0 : 1'($urandom_range(0, 1));
            step = st; dir = d;
            err_m = 1'b0;
            if (st) begin
                if ((!d && idx_m == 32) || (d && idx_m == 1)) err_m = 1'b1;
                else idx_m = d ? idx_m - 1 : idx_m + 1;
            end
            tick();
            check("walk_idx",  80'(key_idx),  80'(idx_m));
            check("walk_kout", k_out,         golden[idx_m]);
            check("walk_err",  80'(step_err), 80'(err_m));
        end
        step = 1'b0; dir = 1'b0;

        // load on the 10th SEEK cycle takes over immediately.
        do_load(key_a);
        seek = 1'b1; tick(); seek = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_seek_busy", 80'(busy), 80'(1));
        do_load(key_b);
        check("reload_idx",   80'(key_idx), 80'(1));
        check("reload_kout",  k_out,        key_b);
        check("reload_busy",  80'(busy),    80'(0));
        check("reload_valid", 80'(valid),   80'(1));

        // Reset mid-seek clears everything.
        seek = 1'b1; tick(); seek = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_kout",  k_out,         80'(0));
        check("rst2_idx",   80'(key_idx),  80'(0));
        check("rst2_valid", 80'(valid),    80'(0));
        check("rst2_busy",  80'(busy),     80'(0));
        check("rst2_err",   80'(step_err), 80'(0));
        tick();
        check("rst2_stays_empty", 80'(valid), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
